// File: rtl/enemy_spawn_scheduler_if.sv
// Spawn-table read channel: the scheduler issues a one-cycle read and the
// table answers some cycles later with a valid strobe and the entry contents.
interface enemy_spawn_scheduler_if #(
  parameter int ADDR_W = 6
);
  logic              tbl_rd;
  logic [ADDR_W-1:0] tbl_addr;
  logic              tbl_valid;
  logic              tbl_en;
  logic              tbl_last;
  logic [9:0]        tbl_x;
  logic [9:0]        tbl_y;

  modport master (
    output tbl_rd, tbl_addr,
    input  tbl_valid, tbl_en, tbl_last, tbl_x, tbl_y
  );

  modport slave (
    input  tbl_rd, tbl_addr,
    output tbl_valid, tbl_en, tbl_last, tbl_x, tbl_y
  );
endinterface

// File: rtl/enemy_spawn_scheduler.sv
// Enemy spawn scheduler: on every room change it walks the room's spawn table,
// loads free enemy slots one at a time and releases them together on a frame tick.
module enemy_spawn_scheduler #(
  parameter int NUM_SLOTS        = 4,
  parameter int ENTRIES_PER_ROOM = 8,
  parameter int TBL_TIMEOUT      = 16
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   frame_clk,
  input  logic [2:0]             roomNum,
  enemy_spawn_scheduler_if.master tbl,
  output logic [NUM_SLOTS-1:0]   slot_load,
  output logic [9:0]             slot_x,
  output logic [9:0]             slot_y,
  output logic [NUM_SLOTS-1:0]   slot_enable,
  input  logic [NUM_SLOTS-1:0]   slot_alive,
  output logic [3:0]             enemies_left,
  output logic                   room_clear,
  output logic                   busy,
  output logic                   tbl_err
);

  localparam int ENTRY_W = $clog2(ENTRIES_PER_ROOM);
  localparam int SLOT_W  = $clog2(NUM_SLOTS + 1);
  localparam int TMO_W   = $clog2(TBL_TIMEOUT);

  localparam logic [ENTRY_W-1:0] ENTRY_LAST = ENTRY_W'(ENTRIES_PER_ROOM - 1);
  localparam logic [SLOT_W-1:0]  SLOT_CNT   = SLOT_W'(NUM_SLOTS);
  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(NUM_SLOTS - 1);
  // The counter is compared before its increment lands, so firing one step
  // early puts tbl_err exactly TBL_TIMEOUT cycles after the read strobe.
  localparam logic [TMO_W-1:0]   TMO_FIRE   = TMO_W'(TBL_TIMEOUT - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_WAIT,
    S_ARM,
    S_RUN
  } state_t;

  state_t               state;
  logic [2:0]           prev_room;
  logic [ENTRY_W-1:0]   entry;
  logic [SLOT_W-1:0]    slot_idx;
  logic [NUM_SLOTS-1:0] loaded;
  logic [TMO_W-1:0]     tmo_cnt;

  logic frame_s1, frame_s2, frame_s3, frame_rise;

  logic [NUM_SLOTS-1:0] slot_onehot;
  logic [ENTRY_W-1:0]   entry_next;
  logic                 load_hit;
  logic [3:0]           live_cnt;

  function automatic logic [3:0] popcount(input logic [NUM_SLOTS-1:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < NUM_SLOTS; i++) n = n + {3'd0, v[i]};
    return n;
  endfunction

  assign slot_onehot = NUM_SLOTS'(1) << slot_idx;
  assign entry_next  = entry + ENTRY_W'(1);
  assign load_hit    = tbl.tbl_valid && tbl.tbl_en && (slot_idx < SLOT_CNT);
  assign live_cnt    = popcount(slot_enable & slot_alive);

  // frame_clk is asynchronous: two-flop synchroniser, then a registered rising edge
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      frame_s1   <= 1'b0;
      frame_s2   <= 1'b0;
      frame_s3   <= 1'b0;
      frame_rise <= 1'b0;
    end else begin
      frame_s1   <= frame_clk;
      frame_s2   <= frame_s1;
      frame_s3   <= frame_s2;
      frame_rise <= frame_s2 & ~frame_s3;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state        <= S_IDLE;
      prev_room    <= 3'd0;
      entry        <= '0;
      slot_idx     <= '0;
      loaded       <= '0;
      tmo_cnt      <= '0;
      tbl.tbl_rd   <= 1'b0;
      tbl.tbl_addr <= '0;
      slot_load    <= '0;
      slot_x       <= 10'd0;
      slot_y       <= 10'd0;
      slot_enable  <= '0;
      enemies_left <= 4'd0;
      room_clear   <= 1'b0;
      busy         <= 1'b0;
      tbl_err      <= 1'b0;
    end else begin
      tbl.tbl_rd   <= 1'b0;
      slot_load    <= '0;
      enemies_left <= live_cnt;
      room_clear   <= (state == S_RUN) && (slot_enable != '0) && (live_cnt == 4'd0);

      // A room change preempts whatever the sequence was doing.
      if (roomNum != prev_room) begin
        prev_room <= roomNum;
        tbl_err   <= 1'b0;
        state     <= S_CLEAR;
      end else begin
        unique case (state)
          S_IDLE: state <= S_IDLE;

          S_CLEAR: begin
            slot_enable <= '0;
            loaded      <= '0;
            entry       <= '0;
            slot_idx    <= '0;
            if (roomNum != 3'd0) begin
              busy         <= 1'b1;
              tbl.tbl_rd   <= 1'b1;
              tbl.tbl_addr <= {roomNum, ENTRY_W'(0)};
              state        <= S_FETCH;
            end else begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end

          S_FETCH: begin
            tmo_cnt <= '0;
            state   <= S_WAIT;
          end

          S_WAIT: begin
            if (tbl.tbl_valid) begin
              if (load_hit) begin
                slot_load <= slot_onehot;
                slot_x    <= tbl.tbl_x;
                slot_y    <= tbl.tbl_y;
                loaded    <= loaded | slot_onehot;
                slot_idx  <= slot_idx + SLOT_W'(1);
              end
              if (tbl.tbl_last || (entry == ENTRY_LAST) ||
                  (load_hit && (slot_idx == SLOT_LAST))) begin
                state <= S_ARM;
              end else begin
                entry        <= entry_next;
                tbl.tbl_rd   <= 1'b1;
                tbl.tbl_addr <= {roomNum, entry_next};
                state        <= S_FETCH;
              end
            end else if (tmo_cnt == TMO_FIRE) begin
              tbl_err <= 1'b1;
              state   <= S_ARM;
            end else begin
              tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
          end

          S_ARM: begin
            if (frame_rise) begin
              slot_enable <= loaded;
              busy        <= 1'b0;
              state       <= S_RUN;
            end
          end

          S_RUN: state <= S_RUN;

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
